// File: rtl/board_text_streamer_pkg.sv
// Shared definitions for the board text streamer.
// Holds the square piece codes, the ASCII constants used on the byte stream
// and the encodings of the streaming state machine.
package board_text_streamer_pkg;

   // Square piece codes: bit 3 selects black, low bits select the piece kind
   localparam int unsigned PIECE_BITS = 4;

   localparam logic [PIECE_BITS-1:0] EMPTY_POSN   = 4'h0;
   localparam logic [PIECE_BITS-1:0] WHITE_PAWN   = 4'h1;
   localparam logic [PIECE_BITS-1:0] WHITE_KNIGHT = 4'h2;
   localparam logic [PIECE_BITS-1:0] WHITE_BISHOP = 4'h3;
   localparam logic [PIECE_BITS-1:0] WHITE_ROOK   = 4'h4;
   localparam logic [PIECE_BITS-1:0] WHITE_QUEEN  = 4'h5;
   localparam logic [PIECE_BITS-1:0] WHITE_KING   = 4'h6;
   localparam logic [PIECE_BITS-1:0] BLACK_PAWN   = 4'h9;
   localparam logic [PIECE_BITS-1:0] BLACK_KNIGHT = 4'hA;
   localparam logic [PIECE_BITS-1:0] BLACK_BISHOP = 4'hB;
   localparam logic [PIECE_BITS-1:0] BLACK_ROOK   = 4'hC;
   localparam logic [PIECE_BITS-1:0] BLACK_QUEEN  = 4'hD;
   localparam logic [PIECE_BITS-1:0] BLACK_KING   = 4'hE;

   // ASCII characters used on the stream
   localparam logic [7:0] ASC_CR    = 8'h0D;
   localparam logic [7:0] ASC_LF    = 8'h0A;
   localparam logic [7:0] ASC_DOT   = 8'h2E;
   localparam logic [7:0] ASC_STAR  = 8'h2A;
   localparam logic [7:0] ASC_PLUS  = 8'h2B;
   localparam logic [7:0] ASC_MINUS = 8'h2D;
   localparam logic [7:0] ASC_QUEST = 8'h3F;
   localparam logic [7:0] ASC_W     = 8'h77;
   localparam logic [7:0] ASC_B     = 8'h62;

   // Streaming state machine encodings
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_SQUARE  = 3'd1;
   localparam logic [2:0] ST_EOL_CR  = 3'd2;
   localparam logic [2:0] ST_EOL_LF  = 3'd3;
   localparam logic [2:0] ST_TRAILER = 3'd4;
   localparam logic [2:0] ST_T_CR    = 3'd5;
   localparam logic [2:0] ST_T_LF    = 3'd6;

endpackage

// File: rtl/board_text_streamer_if.sv
// Byte-wide valid/ready stream.
//   data  : ASCII byte, driven by the master
//   valid : data is valid, driven by the master
//   ready : sink accepts the byte when valid && ready, driven by the slave
interface board_text_streamer_if;
   logic [7:0] data;
   logic       valid;
   logic       ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/board_text_streamer_piece_to_ascii.sv
// Combinational square-code to ASCII translation.
//   i_piece        : square piece code
//   i_white_attack : square is attacked by white
//   i_black_attack : square is attacked by black
//   i_overlay      : mark attacked empty squares instead of printing '.'
//   o_char         : ASCII character for the square
module board_text_streamer_piece_to_ascii
   import board_text_streamer_pkg::*;
(
   input  logic [PIECE_BITS-1:0] i_piece,
   input  logic                  i_white_attack,
   input  logic                  i_black_attack,
   input  logic                  i_overlay,
   output logic [7:0]            o_char
);

   always_comb begin
      o_char = ASC_QUEST;
      case (i_piece)
         EMPTY_POSN: begin
            o_char = ASC_DOT;
            // Only empty squares carry the attack overlay
            if (i_overlay) begin
               case ({i_white_attack, i_black_attack})
                  2'b11:   o_char = ASC_STAR;
                  2'b10:   o_char = ASC_PLUS;
                  2'b01:   o_char = ASC_MINUS;
                  default: o_char = ASC_DOT;
               endcase
            end
         end
         WHITE_PAWN:   o_char = 8'h50;
         WHITE_KNIGHT: o_char = 8'h4E;
         WHITE_BISHOP: o_char = 8'h42;
         WHITE_ROOK:   o_char = 8'h52;
         WHITE_QUEEN:  o_char = 8'h51;
         WHITE_KING:   o_char = 8'h4B;
         BLACK_PAWN:   o_char = 8'h70;
         BLACK_KNIGHT: o_char = 8'h6E;
         BLACK_BISHOP: o_char = 8'h62;
         BLACK_ROOK:   o_char = 8'h72;
         BLACK_QUEEN:  o_char = 8'h71;
         BLACK_KING:   o_char = 8'h6B;
         default:      o_char = ASC_QUEST;
      endcase
   end

endmodule

// File: rtl/board_text_streamer.sv
// Snapshots a board, the side to move and both attack maps on a start pulse
// and streams the position as ASCII text over a byte valid/ready stream.
//   i_clk                : clock
//   i_reset              : synchronous active-low reset
//   i_board              : square codes, square idx = rank*8+file
//   i_white_to_move      : side to move
//   i_white_is_attacking : per-square white attack map
//   i_black_is_attacking : per-square black attack map
//   i_start              : one-cycle request, honoured only when idle
//   o_out                : ASCII byte stream (master)
//   o_busy               : stream in progress
//   o_done               : one-cycle pulse after the last byte is accepted
module board_text_streamer
   import board_text_streamer_pkg::*;
#(
   parameter int unsigned PIECE_WIDTH = PIECE_BITS,
   parameter int unsigned SIDE_WIDTH  = PIECE_WIDTH * 8,
   parameter int unsigned BOARD_WIDTH = SIDE_WIDTH * 8,
   parameter bit          OVERLAY     = 1'b0,
   parameter bit          EOL_CRLF    = 1'b1
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic [BOARD_WIDTH-1:0] i_board,
   input  logic                   i_white_to_move,
   input  logic [63:0]            i_white_is_attacking,
   input  logic [63:0]            i_black_is_attacking,
   input  logic                   i_start,
   board_text_streamer_if.master  o_out,
   output logic                   o_busy,
   output logic                   o_done
);

   logic [2:0]             r_state, w_state_nxt;
   logic [2:0]             r_file, w_file_nxt;
   logic [2:0]             r_rank, w_rank_nxt;
   logic                   r_done, w_done_nxt;
   logic [BOARD_WIDTH-1:0] r_board;
   logic                   r_wtm;
   logic [63:0]            r_wmap, r_bmap;

   logic                   w_valid, w_fire, w_accept_start;
   logic [5:0]             w_sq;
   logic [PIECE_WIDTH-1:0] w_piece;
   logic [7:0]             w_char, w_data;

   assign w_valid        = (r_state != ST_IDLE);
   assign w_fire         = w_valid && o_out.ready;
   assign w_accept_start = (r_state == ST_IDLE) && i_start;
   assign w_sq           = {r_rank, r_file};

   always_comb begin
      w_piece = '0;
      for (int i = 0; i < 64; i++) begin
         if (w_sq == 6'(i)) w_piece = r_board[i*PIECE_WIDTH +: PIECE_WIDTH];
      end
   end

   board_text_streamer_piece_to_ascii u_piece_to_ascii (
      .i_piece        (w_piece),
      .i_white_attack (r_wmap[w_sq]),
      .i_black_attack (r_bmap[w_sq]),
      .i_overlay      (OVERLAY),
      .o_char         (w_char)
   );

   // Output byte is a pure function of held state, so it stays stable on stalls
   always_comb begin
      w_data = 8'h00;
      case (r_state)
         ST_SQUARE:          w_data = w_char;
         ST_EOL_CR, ST_T_CR: w_data = ASC_CR;
         ST_EOL_LF, ST_T_LF: w_data = ASC_LF;
         ST_TRAILER:         w_data = r_wtm ? ASC_W : ASC_B;
         default:            w_data = 8'h00;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_file_nxt  = r_file;
      w_rank_nxt  = r_rank;
      w_done_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               w_state_nxt = ST_SQUARE;
               w_rank_nxt  = 3'd7;
               w_file_nxt  = 3'd0;
            end
         end
         ST_SQUARE: begin
            if (w_fire) begin
               // File wraps 7 -> 0 on its own, ready for the next rank
               w_file_nxt = r_file + 3'd1;
               if (r_file == 3'd7) w_state_nxt = EOL_CRLF ? ST_EOL_CR : ST_EOL_LF;
            end
         end
         ST_EOL_CR: begin
            if (w_fire) w_state_nxt = ST_EOL_LF;
         end
         ST_EOL_LF: begin
            if (w_fire) begin
               if (r_rank != 3'd0) begin
                  w_rank_nxt  = r_rank - 3'd1;
                  w_state_nxt = ST_SQUARE;
               end else begin
                  w_state_nxt = ST_TRAILER;
               end
            end
         end
         ST_TRAILER: begin
            if (w_fire) w_state_nxt = EOL_CRLF ? ST_T_CR : ST_T_LF;
         end
         ST_T_CR: begin
            if (w_fire) w_state_nxt = ST_T_LF;
         end
         ST_T_LF: begin
            if (w_fire) begin
               w_state_nxt = ST_IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state <= ST_IDLE;
         r_file  <= 3'd0;
         r_rank  <= 3'd7;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_file  <= w_file_nxt;
         r_rank  <= w_rank_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // Snapshot is only meaningful while busy, so it needs no reset
   always_ff @(posedge i_clk) begin
      if (w_accept_start) begin
         r_board <= i_board;
         r_wtm   <= i_white_to_move;
         r_wmap  <= i_white_is_attacking;
         r_bmap  <= i_black_is_attacking;
      end
   end

   assign o_out.data  = w_data;
   assign o_out.valid = w_valid;
   assign o_busy      = w_valid;
   assign o_done      = r_done;

endmodule

// File: tb/tb_board_text_streamer.sv
// Directed bench for board_text_streamer: two instances, one plain with CR LF
// line endings and one with the attack overlay and LF-only line endings.
module tb_board_text_streamer;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [255:0] board;
   logic         wtm;
   logic [63:0]  wmap, bmap;
   logic         start, sel, ready;
   logic         start_a, start_b, busy_a, busy_b, done_a, done_b;
   logic         cur_valid, cur_busy, cur_done;
   logic [7:0]   cur_data;

   int           n_checks = 0;
   int           n_fail = 0;
   logic [7:0]   got[$];
   logic [7:0]   exp_q[$];
   string        rows[8];
   int           ncyc;

   always #5 clk = ~clk;

   board_text_streamer_if u_if_a ();
   board_text_streamer_if u_if_b ();

   assign u_if_a.ready = ready;
   assign u_if_b.ready = ready;
   assign start_a = start & ~sel;
   assign start_b = start & sel;

   board_text_streamer #(.OVERLAY(1'b0), .EOL_CRLF(1'b1)) u_dut_a (
      .i_clk                (clk),
      .i_reset              (rst_n),
      .i_board              (board),
      .i_white_to_move      (wtm),
      .i_white_is_attacking (wmap),
      .i_black_is_attacking (bmap),
      .i_start              (start_a),
      .o_out                (u_if_a.master),
      .o_busy               (busy_a),
      .o_done               (done_a)
   );

   board_text_streamer #(.OVERLAY(1'b1), .EOL_CRLF(1'b0)) u_dut_b (
      .i_clk                (clk),
      .i_reset              (rst_n),
      .i_board              (board),
      .i_white_to_move      (wtm),
      .i_white_is_attacking (wmap),
      .i_black_is_attacking (bmap),
      .i_start              (start_b),
      .o_out                (u_if_b.master),
      .o_busy               (busy_b),
      .o_done               (done_b)
   );

   assign cur_valid = sel ? u_if_b.valid : u_if_a.valid;
   assign cur_data  = sel ? u_if_b.data : u_if_a.data;
   assign cur_busy  = sel ? busy_b : busy_a;
   assign cur_done  = sel ? done_b : done_a;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic put(input int idx, input logic [3:0] code);
      board[idx*4 +: 4] = code;
   endtask

   task automatic dot_rows();
      for (int r = 0; r < 8; r++) rows[r] = "........";
   endtask

   task automatic build_expected(input bit crlf, input bit white);
      exp_q.delete();
      for (int r = 7; r >= 0; r--) begin
         for (int f = 0; f < 8; f++) exp_q.push_back(rows[r].getc(f));
         if (crlf) exp_q.push_back(8'h0D);
         exp_q.push_back(8'h0A);
      end
      exp_q.push_back(white ? 8'h77 : 8'h62);
      if (crlf) exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
   endtask

   task automatic compare_stream(input string tag);
      check({tag, "_len"}, got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         check($sformatf("%s_byte%0d", tag, i), got[i], exp_q[i]);
   endtask

   // Collects bytes from the selected DUT until out_valid drops. Ends on the
   // negedge where done should be high, or just after a mid-stream reset.
   task automatic drain(input bit toggle, input int restart_at, input int reset_at,
                        output int n);
      logic [7:0] prev_data;
      bit         prev_stall, finished;
      prev_data = 8'h00;
      prev_stall = 1'b0;
      finished = 1'b0;
      n = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (!cur_valid) begin
            finished = 1'b1;
            break;
         end
         n++;
         ready = toggle ? (cyc % 2 == 0) : 1'b1;
         if (prev_stall) check("stall_hold", 32'(cur_data), 32'(prev_data));
         if (ready) got.push_back(cur_data);
         prev_stall = !ready;
         prev_data = cur_data;
         start = (restart_at >= 0 && got.size() == restart_at);
         if (start) board = '1;
         if (reset_at >= 0 && got.size() == reset_at) begin
            rst_n = 1'b0;
            @(negedge clk);
            check("reset_valid", 32'(cur_valid), 0);
            check("reset_busy", 32'(cur_busy), 0);
            check("reset_done", 32'(cur_done), 0);
            rst_n = 1'b1;
            ready = 1'b1;
            return;
         end
         @(negedge clk);
      end
      start = 1'b0;
      ready = 1'b1;
      check("stream_end", 32'(finished), 1);
      check("done_pulse", 32'(cur_done), 1);
      check("busy_after", 32'(cur_busy), 0);
   endtask

   task automatic run_stream(input bit toggle, input int restart_at, input int reset_at,
                             output int n);
      got.delete();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("first_latency", 32'(cur_valid), 1);
      drain(toggle, restart_at, reset_at, n);
   endtask

   task automatic done_drops();
      @(negedge clk);
      check("done_one_cycle", 32'(cur_done), 0);
   endtask

   initial begin
      rst_n = 1'b0;
      board = '0;
      wtm = 1'b1;
      wmap = '0;
      bmap = '0;
      start = 1'b0;
      sel = 1'b0;
      ready = 1'b1;
      repeat (2) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         check("rst_valid", 32'(cur_valid), 0);
         check("rst_busy", 32'(cur_busy), 0);
         check("rst_done", 32'(cur_done), 0);
         check("rst_data", 32'(cur_data), 0);
      end
      sel = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Empty board, CR LF, white to move
      dot_rows();
      build_expected(1'b1, 1'b1);
      run_stream(1'b0, -1, -1, ncyc);
      compare_stream("empty");
      check("empty_cycles", ncyc, 83);
      done_drops();

      // Black rook idx 36, white pawns idx 35 and 28
      put(36, 4'hC);
      put(35, 4'h1);
      put(28, 4'h1);
      dot_rows();
      rows[4] = "...Pr...";
      rows[3] = "....P...";
      build_expected(1'b1, 1'b1);
      run_stream(1'b0, -1, -1, ncyc);
      compare_stream("pos");
      done_drops();

      // Same position on the overlay instance, black to move, LF only
      sel = 1'b1;
      wtm = 1'b0;
      wmap[27] = 1'b1;
      bmap[27] = 1'b1;
      bmap[44] = 1'b1;
      rows[3] = "...*P...";
      rows[5] = "....-...";
      build_expected(1'b0, 1'b0);
      run_stream(1'b0, -1, -1, ncyc);
      compare_stream("overlay");
      check("overlay_cycles", ncyc, 74);
      done_drops();

      // Backpressure: ready toggles every cycle
      sel = 1'b0;
      wtm = 1'b1;
      board = '0;
      wmap = '0;
      bmap = '0;
      dot_rows();
      build_expected(1'b1, 1'b1);
      run_stream(1'b1, -1, -1, ncyc);
      compare_stream("bp");
      check("bp_cycles", ncyc, 165);
      done_drops();

      // Start re-pulsed at byte 10 with a changed board: both ignored
      run_stream(1'b0, 10, -1, ncyc);
      compare_stream("restart");
      done_drops();

      // Reset at byte 40, then a fresh stream from rank 7 file 0
      board = '0;
      run_stream(1'b0, -1, 40, ncyc);
      check("reset_partial", got.size(), 40);
      run_stream(1'b0, -1, -1, ncyc);
      compare_stream("after_rst");
      done_drops();

      // Every piece letter, undefined codes, overlay hiding under pieces
      sel = 1'b1;
      board = '0;
      wmap = '1;
      bmap = '0;
      for (int f = 0; f < 8; f++) begin
         put(8 + f, 4'h1);
         put(48 + f, 4'h9);
      end
      put(0, 4'h4); put(1, 4'h2); put(2, 4'h3); put(3, 4'h5);
      put(4, 4'h6); put(5, 4'h3); put(6, 4'h2); put(7, 4'h4);
      put(56, 4'hC); put(57, 4'hA); put(58, 4'hB); put(59, 4'hD);
      put(60, 4'hE); put(61, 4'hB); put(62, 4'hA); put(63, 4'hC);
      put(16, 4'h7); put(17, 4'h8); put(18, 4'hF);
      rows[0] = "RNBQKBNR";
      rows[1] = "PPPPPPPP";
      rows[2] = "???+++++";
      rows[3] = "++++++++";
      rows[4] = "++++++++";
      rows[5] = "++++++++";
      rows[6] = "pppppppp";
      rows[7] = "rnbqkbnr";
      build_expected(1'b0, 1'b1);
      run_stream(1'b0, -1, -1, ncyc);
      compare_stream("pieces");

      // Start in the same cycle as done is accepted
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("chain_valid", 32'(cur_valid), 1);
      check("chain_first", 32'(cur_data), 32'(exp_q[0]));
      got.delete();
      drain(1'b0, -1, -1, ncyc);
      compare_stream("chain");
      done_drops();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/board_text_streamer.md
Name: board_text_streamer

Overview:
- Synthesizable successor to the simulation-only board display: snapshots a board, side to move and both attack maps on a start pulse.
- Streams the position as ASCII text over a byte valid/ready interface, for UART/AXI-stream bridges in hardware debug.
- Parametrised in line-ending style and in attack-overlay mode; supports backpressure.
- Sits beside vchess and is driven by its attack-done strobe.

Parameters:
- PIECE_WIDTH, `PIECE_BITS, bits per square code
- SIDE_WIDTH, PIECE_WIDTH*8, bits per rank
- BOARD_WIDTH, PIECE_WIDTH*64, bits per board
- OVERLAY, 0, 1 = mark attacked empty squares; 0 = plain board
- EOL_CRLF, 1, 1 = each line ends CR LF (0x0D 0x0A); 0 = LF only

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- board  in  BOARD_WIDTH  square idx = rank*8+file, code at board[idx*PIECE_WIDTH+:PIECE_WIDTH]; rank 0 = white back rank
- white_to_move  in  1  side to move
- white_is_attacking  in  64  per-square white attack map
- black_is_attacking  in  64  per-square black attack map
- start  in  1  one-cycle request to emit the snapshot
- out_data  out  8  ASCII byte
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts byte when out_valid && out_ready
- busy  out  1  stream in progress
- done  out  1  one-cycle pulse after the last byte is accepted

Behaviour:
- Reset (reset==0 at posedge):
  - out_valid=0, busy=0, done=0, out_data=0x00; state IDLE.
  - Applies mid-stream: the next cycle shows out_valid=0 and no further bytes; the partial stream is abandoned.
- Start:
  - start is accepted only in IDLE. It latches board, white_to_move and both maps. busy=1 and out_valid=1 from the next cycle, so first-byte latency is 1 cycle.
  - start while busy is ignored, with no queueing. Input changes after acceptance do not affect the stream.
- Byte order:
  - For rank 7 down to 0, file 0 to 7, one character per square, then EOL.
  - Then the trailer line: 'w' (0x77) if white_to_move, else 'b' (0x62), then EOL.
  - Total bytes: 83 with EOL_CRLF=1; 74 with EOL_CRLF=0.
- Character map:
  - White pieces: P N B R Q K. Black pieces: p n b r q k.
  - Empty square: '.'. Any undefined code: '?'.
- Overlay (OVERLAY=1, empty squares only):
  - Both sides attack: '*'. White only: '+'. Black only: '-'. Neither: '.'.
  - Occupied squares are never overlaid.
- Handshake:
  - While out_valid && !out_ready, out_data and the state are held stable.
  - A byte advances only on the handshake. out_valid never drops mid-stream except on reset.
  - Back-to-back transfers run at 1 byte/cycle.
- State machine:
  - IDLE -> SQUARE (start)
  - SQUARE -> EOL_CR (file 7 accepted, EOL_CRLF=1) or EOL_LF
  - EOL_CR -> EOL_LF
  - EOL_LF -> SQUARE (rank > 0, rank decrements, file = 0) or TRAILER (rank 0)
  - TRAILER -> T_CR / T_LF
  - T_CR -> T_LF
  - T_LF -> IDLE on accept, with done=1 and busy=0 in the following cycle
- Counters: 3-bit file counter and 3-bit rank counter; rank starts at 7, file at 0.
- A start arriving in the same cycle as the done pulse is accepted, since the block is already in IDLE.

Decomposition:
- Shared header vchess.vh holds the piece codes (`EMPTY_POSN, `WHITE_*, `BLACK_*, `PIECE_BITS) plus new ASCII constants (`ASC_CR, `ASC_LF, `ASC_DOT, `ASC_STAR, `ASC_PLUS, `ASC_MINUS).
- One combinational sub-module, piece_to_ascii (inputs: piece code, white attack bit, black attack bit, overlay enable; output: 8-bit char), is shared with future FEN output.

Test Plan:
- Empty board, OVERLAY=0, EOL_CRLF=1, white_to_move=1, out_ready=1:
  - Expect 83 bytes: eight copies of "........\r\n" then "w\r\n".
  - done pulses once, 1 cycle after the last byte; busy low afterwards.
- Black rook at idx 36, white pawns at idx 35 and 28:
  - Rank-5 line is "...Pr...\r\n"; rank-4 line is "....P...\r\n"; all other ranks are dots.
- Same position with OVERLAY=1, white map bit 27 only, black map bits 27 and 44:
  - Rank-4 line is "...*P...".
  - Rank-6 line is "....-...".
- Backpressure, out_ready toggling every cycle:
  - Identical byte sequence to the first test.
  - out_data is stable across every stalled cycle; the stream takes 165 cycles.
- start re-pulsed at byte 10:
  - Ignored; exactly 83 bytes emitted.
  - A board change after the first start does not alter the output.
- reset low at byte 40:
  - out_valid=0 and busy=0 the next cycle.
  - A fresh start after reset is released restarts from rank 7, file 0.
